line_mem_responder: RTL and testbench

//  Line-granular main-memory responder on the data-cache refill/writeback port.

---
 rtl/line_mem_responder_if.sv | 40 ++++
 rtl/line_mem_responder.sv | 138 +++++++++++++
 tb/tb_line_mem_responder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_responder_if.sv
// ---------------------------------------------------------------------------
// line_mem_responder_if
// Request/response bundle between the data-cache refill/writeback port
// (initiator, master modport) and the line memory (responder, slave modport).
//
// Signals
//   req_valid   initiator -> responder   request present
//   req_ready   responder -> initiator   responder can accept
//   req_we      initiator -> responder   1 = write line, 0 = read line
//   req_addr    initiator -> responder   line address
//   req_wdata   initiator -> responder   write line data
//   rsp_valid   responder -> initiator   response present
//   rsp_ready   initiator -> responder   initiator takes response
//   rsp_we      responder -> initiator   echo of the accepted req_we
//   rsp_rdata   responder -> initiator   read data, or the line just written
// ---------------------------------------------------------------------------
interface line_mem_responder_if #(
    parameter int LINE_W = 512,
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [LINE_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_we, rsp_rdata
    );
endinterface

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
// Line-granular main-memory responder for the data-cache refill/writeback
// port. Holds 2**ADDR_W lines of LINE_W bits, accepts one read or write line
// request at a time, waits LATENCY cycles, commits, and presents a response
// until the initiator takes it.
//
// Ports
//   CLK        in   clock, rising edge
//   CLR        in   asynchronous reset, active-high
//   bus        slave modport of line_mem_responder_if (req/rsp handshake)
//   rd_count   out  committed reads  (only with MEM_STATS_EN)
//   wr_count   out  committed writes (only with MEM_STATS_EN)
//
// Configuration
//   MEM_STATS_EN  when defined, adds the rd_count/wr_count commit counters.
//
// State table
//   IDLE | req_ready high, waiting for a request
//   WAIT | counting down the latency; commits when the count reaches zero
//   RESP | rsp_valid high, holding the response until rsp_ready
//
// The line array is named RAM so that benches can preload it or dump it
// hierarchically. It is deliberately not reset.
// ---------------------------------------------------------------------------
module line_mem_responder #(
    parameter int LINE_W  = 512,
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 4
) (
    input  logic                 CLK,
    input  logic                 CLR,
    line_mem_responder_if.slave  bus
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
`endif
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [7:0] LAT   = 8'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        wait_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;

    logic [LINE_W-1:0] RAM [DEPTH-1:0];

    // Commit happens on the edge that leaves WAIT. Every request spends at
    // least one cycle in WAIT, so the response appears LATENCY+1 edges after
    // the accepting edge, including the LATENCY=0 case.
    logic commit;
    assign commit = (state == WAIT) && (wait_cnt == 8'd0);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_we    <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we        <= bus.req_we;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        wait_cnt      <= LAT;
                        bus.req_ready <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_we    <= lat_we;
                        bus.rsp_rdata <= lat_we ? lat_wdata : RAM[lat_addr];
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                RESP: begin
                    // Retire to IDLE first; the next request is accepted on
                    // the following edge at the earliest.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Array write. A reset forces IDLE, so no commit can be pending while
    // CLR is high; a write that already committed stays in the array.
    always_ff @(posedge CLK) begin
        if (commit && lat_we) begin
            RAM[lat_addr] <= lat_wdata;
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (commit) begin
            if (lat_we) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

    localparam int LINE_W = 512;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int LAT    = 4;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    line_mem_responder_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();
    line_mem_responder_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus0 ();

`ifdef MEM_STATS_EN
    logic [31:0] rd_count, wr_count, rd_count0, wr_count0;
`endif

    line_mem_responder #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .bus      (bus)
`ifdef MEM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    line_mem_responder #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .LATENCY(0)) dut0 (
        .CLK      (CLK),
        .CLR      (CLR),
        .bus      (bus0)
`ifdef MEM_STATS_EN
        ,
        .rd_count (rd_count0),
        .wr_count (wr_count0)
`endif
    );

    // Reference model: what each line should hold, plus commit counts.
    logic [LINE_W-1:0] model [DEPTH];
    int exp_rd = 0;
    int exp_wr = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic pulse_clr();
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
    endtask

    // Present a request at the current negedge and return once it is accepted.
    task automatic send_req(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [LINE_W-1:0] data, output int acc_cyc);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_timeout got %b want 1", bus.req_ready);
        end
        @(posedge CLK);
        #1 acc_cyc = cyc;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom());
        bus.req_addr  = ADDR_W'($urandom());
        bus.req_wdata = rand_line();
    endtask

    task automatic wait_rsp(input int acc_cyc, output int edges);
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        edges = cyc - acc_cyc;
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_valid_timeout got %b want 1", bus.rsp_valid);
        end
    endtask

    // Full transaction: request, latency check, data check, optional
    // backpressure of `hold` cycles, retire.
    task automatic txn(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] data, input int hold,
                       output int acc_cyc, output logic [LINE_W-1:0] got);
        int edges;
        logic [LINE_W-1:0] exp;
        exp = we ? data : model[addr];
        send_req(we, addr, data, acc_cyc);
        wait_rsp(acc_cyc, edges);
        checks++;
        if (edges != LAT + 1) begin
            errors++;
            $display("FAIL latency got %0d want %0d", edges, LAT + 1);
        end
        checks++;
        if (bus.rsp_we !== we) begin
            errors++;
            $display("FAIL rsp_we got %b want %b", bus.rsp_we, we);
        end
        checks++;
        if (bus.rsp_rdata !== exp) begin
            errors++;
            $display("FAIL rsp_rdata addr %0d got %h want %h", addr, bus.rsp_rdata, exp);
        end
        got = bus.rsp_rdata;
        if (we) begin
            model[addr] = data;
            exp_wr++;
        end else begin
            exp_rd++;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp) begin
                errors++;
                $display("FAIL rsp_hold valid %b data %h want 1 %h", bus.rsp_valid, bus.rsp_rdata, exp);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL retire rsp_valid %b req_ready %b want 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic check_stats(input string name);
`ifdef MEM_STATS_EN
        checks++;
        if (rd_count !== 32'(exp_rd) || wr_count !== 32'(exp_wr)) begin
            errors++;
            $display("FAIL %s rd %0d wr %0d want %0d %0d", name, rd_count, wr_count, exp_rd, exp_wr);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic test_reset_state();
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_we !== 1'b0 ||
            bus.rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_state ready %b valid %b we %b data %h want 1 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_rdata);
        end
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    task automatic preload();
        int a;
        logic [LINE_W-1:0] g;
        for (int i = 0; i < DEPTH; i++) txn(1'b1, ADDR_W'(i), rand_line(), 0, a, g);
        check_stats("stats_preload");
    endtask

    // CLR while a read response is pending: outputs clear at once, RAM stays.
    task automatic test_reset();
        int a, e;
        logic [LINE_W-1:0] g;
        send_req(1'b0, 6'd5, '0, a);
        wait_rsp(a, e);
        #2 CLR = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 ||
            bus.rsp_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_async ready %b valid %b data %h want 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
        end
        @(negedge CLK);
        CLR = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        check_stats("stats_after_clr");
        txn(1'b0, 6'd5, '0, 0, a, g);
    endtask

    task automatic test_read_pattern();
        int a;
        logic [LINE_W-1:0] pat, g;
        for (int i = 0; i < LINE_W / 8; i++) pat[i*8 +: 8] = 8'(i);
        txn(1'b1, 6'd3, pat, 0, a, g);
        txn(1'b0, 6'd3, '0, 0, a, g);
        checks++;
        if (g[31:0] !== 32'h0302_0100) begin
            errors++;
            $display("FAIL read_word0 got %h want 03020100", g[31:0]);
        end
    endtask

    task automatic test_write_read();
        int a;
        logic [LINE_W-1:0] g;
        txn(1'b1, 6'd63, {16{32'hDEAD_BEEF}}, 0, a, g);
        txn(1'b0, 6'd63, '0, 0, a, g);
        checks++;
        if (g !== {16{32'hDEAD_BEEF}}) begin
            errors++;
            $display("FAIL raw_63 got %h want deadbeef x16", g);
        end
        txn(1'b0, 6'd0, '0, 0, a, g);
    endtask

    task automatic test_backpressure();
        int a, e;
        logic [LINE_W-1:0] exp, d;
        exp = model[12];
        d = rand_line();
        send_req(1'b0, 6'd12, '0, a);
        wait_rsp(a, e);
        exp_rd++;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 6'd10;
        bus.req_wdata = d;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure valid %b ready %b data %h want 1 0 %h",
                         bus.rsp_valid, bus.req_ready, bus.rsp_rdata, exp);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_retire valid %b ready %b want 0 1", bus.rsp_valid, bus.req_ready);
        end
        @(posedge CLK);
        #1 a = cyc;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept req_ready got %b want 0", bus.req_ready);
        end
        wait_rsp(a, e);
        checks++;
        if (e != LAT + 1 || bus.rsp_rdata !== d || bus.rsp_we !== 1'b1) begin
            errors++;
            $display("FAIL bp_next edges %0d we %b data %h want %0d 1 %h", e, bus.rsp_we,
                     bus.rsp_rdata, LAT + 1, d);
        end
        model[10] = d;
        exp_wr++;
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_latency0();
        int k;
        logic [LINE_W-1:0] d;
        d = rand_line();
        for (int pass = 0; pass < 2; pass++) begin
            bus0.req_valid = 1'b1;
            bus0.req_we    = (pass == 0);
            bus0.req_addr  = 6'd9;
            bus0.req_wdata = d;
            @(posedge CLK);
            #1 k = cyc;
            @(negedge CLK);
            bus0.req_valid = 1'b0;
            bus0.req_wdata = '0;
            checks++;
            if (bus0.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL lat0_early cyc %0d rsp_valid got %b want 0", cyc - k, bus0.rsp_valid);
            end
            @(negedge CLK);
            checks++;
            if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== d || bus0.rsp_we !== (pass == 0)) begin
                errors++;
                $display("FAIL lat0_rsp valid %b we %b data %h want 1 %b %h", bus0.rsp_valid,
                         bus0.rsp_we, bus0.rsp_rdata, (pass == 0), d);
            end
            bus0.rsp_ready = 1'b1;
            @(negedge CLK);
            bus0.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_clr_wait();
        int a;
        logic [LINE_W-1:0] g;
        send_req(1'b1, 6'd7, ~model[7], a);
        @(negedge CLK);
        CLR = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_wait ready %b valid %b want 1 0", bus.req_ready, bus.rsp_valid);
        end
        @(negedge CLK);
        CLR = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        txn(1'b0, 6'd7, '0, 0, a, g);
    endtask

    task automatic test_random();
        int a;
        logic [LINE_W-1:0] g;
        for (int i = 0; i < 24; i++)
            txn(1'($urandom()), ADDR_W'($urandom()), rand_line(), int'($urandom_range(0, 3)), a, g);
        check_stats("stats_random");
    endtask

    task automatic test_back_to_back();
        int a, prev;
        logic [LINE_W-1:0] g;
        txn(1'b0, ADDR_W'($urandom()), '0, 0, prev, g);
        for (int i = 0; i < 4; i++) begin
            txn(1'($urandom()), ADDR_W'($urandom()), rand_line(), 0, a, g);
            checks++;
            if (a - prev != LAT + 3) begin
                errors++;
                $display("FAIL throughput spacing got %0d want %0d", a - prev, LAT + 3);
            end
            prev = a;
        end
    endtask

    task automatic test_stats();
        int a;
        logic [LINE_W-1:0] g;
        pulse_clr();
        check_stats("stats_zero");
        for (int i = 0; i < 3; i++) txn(1'b0, ADDR_W'($urandom()), '0, 0, a, g);
        for (int i = 0; i < 2; i++) txn(1'b1, ADDR_W'($urandom()), rand_line(), 0, a, g);
        check_stats("stats_3r2w");
        pulse_clr();
        check_stats("stats_cleared");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b0;
        @(negedge CLK);
        test_reset_state();
        preload();
        test_reset();
        test_read_pattern();
        test_write_read();
        test_backpressure();
        test_latency0();
        test_clr_wait();
        test_random();
        test_back_to_back();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
